seven_seg_scan_driver: RTL and testbench

- Multi-digit, time-multiplexed 7-segment display driver for the board's common-anode display.
- Accepts an unsigned binary value through a load handshake and converts it to BCD with a sequential double-dabble engine, one shift per clock.
- Scans the digits with active-low anode and segment outputs.
- Sits between datapath or lab logic and the display pins; replaces per-digit combinational decoders.

---
 rtl/seven_seg_scan_driver_if.sv | 27 ++
 rtl/seven_seg_scan_driver.sv | 196 +++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// Bus between the value source and the seven-segment scan driver, including the display pins.
// master = lab/datapath side, slave = the driver.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
);
  logic [BIN_W-1:0]      bin_in;
  logic                  load;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blank;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [NUM_DIGITS-1:0] an;
  logic [0:6]            seg;
  logic                  dp;

  modport master (
    output bin_in, load, dp_in, blank,
    input  busy, done, ovf, an, seg, dp
  );

  modport slave (
    input  bin_in, load, dp_in, blank,
    output busy, done, ovf, an, seg, dp
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a sequential double-dabble BCD converter.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks the segments of leading-zero digits.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input logic                    clk,
  input logic                    rst_n,
  seven_seg_scan_driver_if.slave bus
);

  function automatic int bcd_digits(input int w);
    longint unsigned v;
    int n;
    v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        n++;
      end
    end
    return n;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int BIN_D = bcd_digits(BIN_W);
  localparam int BCD_D = (BIN_D > NUM_DIGITS) ? BIN_D : NUM_DIGITS;
  localparam int BCD_W = 4 * BCD_D;
  localparam longint unsigned LIMIT = pow10(NUM_DIGITS) - 64'd1;
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_D; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [0:6] seg_encode(input logic [3:0] n);
    case (n)
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [BIN_W-1:0]        cap, bin_sh;
  logic [BCD_W-1:0]        bcd;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    ovf_r, done_r, busy_c;
  logic [DIV_W-1:0]        div;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   an_r;
  logic [0:6]              seg_r, seg_nxt;
  logic                    dp_r, dp_sel;
  logic [3:0]              nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
  end

  // Converter control; the display register only moves at COMMIT so partial BCD never shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      disp   <= '0;
    end else begin
      done_r <= (state == COMMIT);
      case (state)
        IDLE:    if (bus.load) cnt <= CNT_W'(BIN_W);
        SHIFT:   cnt <= cnt - CNT_W'(1);
        COMMIT: begin
          disp  <= bcd[4*NUM_DIGITS-1:0];
          ovf_r <= (64'(cap) > LIMIT);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.load) begin
      cap    <= bus.bin_in;
      bin_sh <= bus.bin_in;
      bcd    <= '0;
    end else if (state == SHIFT) begin
      {bcd, bin_sh} <= {add3_all(bcd), bin_sh} << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_W'(REFRESH_DIV - 1)) begin
      div <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  lz_sel;

  // zero_from[d]: digit d and every digit above it are zero.
  always_comb begin
    zero_from[NUM_DIGITS-1] = (disp[4*(NUM_DIGITS-1) +: 4] == 4'd0);
    for (int d = NUM_DIGITS - 2; d >= 0; d--) begin
      zero_from[d] = zero_from[d+1] && (disp[4*d +: 4] == 4'd0);
    end
  end
`endif

  always_comb begin
    nib     = 4'd0;
    dp_sel  = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    lz_sel  = 1'b0;
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx == IDX_W'(d)) begin
        nib    = disp[4*d +: 4];
        dp_sel = bus.dp_in[d];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        lz_sel = (d != 0) && zero_from[d];
`endif
      end
    end
    seg_nxt = ovf_r ? 7'b1111110 : seg_encode(nib);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (!ovf_r && lz_sel) seg_nxt = 7'b1111111;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= '1;
      seg_r <= '1;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= bus.blank ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg_r <= seg_nxt;
      dp_r  <= ~dp_sel;
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_r;
  assign bus.ovf  = ovf_r;
  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = dp_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: value-level display model compared every cycle plus directed literal checks.
module tb_seven_seg_scan_driver;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int RD = 4;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   done_seen = 0;
  int   busy_cycles = 0;

  seven_seg_scan_driver_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus ();

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [0:6] model_seg(input int val, input bit ov, input int di);
    int dig;
    if (ov) return 7'b1111110;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (di > 0 && val < pow10(di)) return 7'b1111111;
`endif
    dig = (val / pow10(di)) % 10;
    case (dig)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // Model: value shown, overflow flag, and a countdown for the conversion in flight.
  int         m_t, m_cnt, m_val, m_disp, m_idx;
  bit         m_ovf;
  logic [3:0] exp_an;
  logic [0:6] exp_seg;
  logic       exp_dp, exp_busy, exp_done, exp_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_cnt = 0; m_val = 0; m_disp = 0; m_ovf = 0;
      exp_an = 4'hF; exp_seg = 7'b1111111; exp_dp = 1'b1;
      exp_busy = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0;
    end else begin
      m_idx   = (m_t / RD) % ND;
      m_t++;
      exp_an  = bus.blank ? 4'hF : ~(4'b0001 << m_idx);
      exp_seg = model_seg(m_disp, m_ovf, m_idx);
      exp_dp  = ~bus.dp_in[m_idx];
      exp_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_disp   = m_val;
          m_ovf    = (m_val > pow10(ND) - 1);
          exp_done = 1'b1;
        end
      end else if (bus.load) begin
        m_val = int'(bus.bin_in);
        m_cnt = BW + 1;
      end
      exp_busy = (m_cnt > 0);
      exp_ovf  = m_ovf;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("an", bus.an, exp_an);
    chk("seg", bus.seg, exp_seg);
    chk("dp", bus.dp, exp_dp);
    chk("busy", bus.busy, exp_busy);
    chk("done", bus.done, exp_done);
    chk("ovf", bus.ovf, exp_ovf);
    if (bus.done === 1'b1) done_seen++;
    if (bus.busy === 1'b1) busy_cycles++;
  end

  task automatic wait_an(input logic [3:0] tgt, input string nm);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.an === tgt) break;
    end
    chk(nm, bus.an, tgt);
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) break;
    end
    chk(nm, bus.done, 1);
  endtask

  task automatic load_val(input int v);
    @(negedge clk);
    bus.bin_in = BW'(v);
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  logic [0:6] lit_1234 [4];
  logic [0:6] lz_seg;
  int d0, b0;

  initial begin
    lit_1234[0] = 7'b1001100;
    lit_1234[1] = 7'b0000110;
    lit_1234[2] = 7'b0010010;
    lit_1234[3] = 7'b1001111;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    lz_seg = 7'b1111111;
`else
    lz_seg = 7'b0000001;
`endif
    rst_n = 1'b0;
    bus.bin_in = '0; bus.load = 1'b0; bus.dp_in = 4'b0010; bus.blank = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);

    // Asynchronous reset mid-scan while digit 1 (with its dp) is lit.
    rst_n = 1'b0;
    #1;
    chk("rst_an", bus.an, 4'b1111);
    chk("rst_seg", bus.seg, 7'b1111111);
    chk("rst_dp", bus.dp, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_an", bus.an, 4'b1110);
      chk("post_rst_seg", bus.seg, 7'b0000001);
    end

    // 1234 with an ignored load of 42 while busy.
    d0 = done_seen; b0 = busy_cycles;
    load_val(1234);
    repeat (3) @(negedge clk);
    load_val(42);
    wait_done("done_1234");
    repeat (20) @(negedge clk);
    chk("done_count", done_seen - d0, 1);
    chk("busy_len", busy_cycles - b0, 15);
    for (int d = 0; d < ND; d++) begin
      wait_an(~(4'b0001 << d), "scan_1234");
      chk("seg_1234", bus.seg, lit_1234[d]);
    end

    // Overflow, then back in range.
    load_val(10000);
    wait_done("done_ovf");
    chk("ovf_set", bus.ovf, 1);
    for (int d = 0; d < ND; d++) begin
      wait_an(~(4'b0001 << d), "scan_ovf");
      chk("seg_dash", bus.seg, 7'b1111110);
    end
    load_val(7);
    wait_done("done_7");
    chk("ovf_clr", bus.ovf, 0);
    wait_an(4'b1110, "scan_7a");
    chk("seg_7", bus.seg, 7'b0001111);
    wait_an(4'b1101, "scan_7b");
    chk("seg_7_lz", bus.seg, lz_seg);

    // Reset five cycles into a conversion.
    load_val(1234);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    wait_an(4'b1110, "scan_abort0");
    chk("abort_seg0", bus.seg, 7'b0000001);
    wait_an(4'b0111, "scan_abort3");
    chk("abort_seg3", bus.seg, lz_seg);

    // Blank and decimal point.
    @(negedge clk);
    bus.blank = 1'b1;
    @(posedge clk); #1;
    chk("blank_an", bus.an, 4'b1111);
    repeat (6) @(negedge clk);
    bus.blank = 1'b0;
    wait_an(4'b1101, "scan_dp1");
    chk("dp_on", bus.dp, 0);
    wait_an(4'b1110, "scan_dp0");
    chk("dp_off", bus.dp, 1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
